// File: rtl/pipeline_types.sv
// Shared types for the cache/memory arbiter: bus widths, FSM states, owner encoding.
// Optional feature macro used by the arbiter files: ARB_ROUND_ROBIN_EN.
package pipeline_types;

  typedef logic [31:0]  bus32_t;
  typedef logic [255:0] bus256_t;

  localparam int BUS32_W  = $bits(bus32_t);
  localparam int BUS256_W = $bits(bus256_t);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_IC    = 2'd1,
    OWN_DC_RD = 2'd2,
    OWN_DC_WR = 2'd3
  } owner_e;

  // True when the owner belongs to the dcache requester class.
  function automatic logic is_dcache(input owner_e o);
    return (o == OWN_DC_RD) || (o == OWN_DC_WR);
  endfunction

endpackage

// File: rtl/cache_arb_grant.sv
// Grant selection for the cache/memory arbiter.
// Default: fixed priority dcache write > dcache read > icache read.
// With ARB_ROUND_ROBIN_EN: a last-grant pointer alternates icache/dcache classes
// when both request; writeback still precedes refill inside the dcache class.
module cache_arb_grant
  import pipeline_types::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  logic   clk,
  input  logic   rst,
  input  logic   i_take,
`endif
  input  logic   i_ic_req,
  input  logic   i_dc_rd_req,
  input  logic   i_dc_wr_req,
  output owner_e o_grant
);

  owner_e w_dc_pick;

  // Pick inside the dcache class: a victim writeback always beats its refill.
  always_comb begin
    w_dc_pick = OWN_NONE;
    if (i_dc_wr_req) begin
      w_dc_pick = OWN_DC_WR;
    end else if (i_dc_rd_req) begin
      w_dc_pick = OWN_DC_RD;
    end else begin
      w_dc_pick = OWN_NONE;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_dc;

  // Remember which class won the most recent grant (starts as dcache).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_dc <= 1'b1;
    end else if (i_take && (o_grant != OWN_NONE)) begin
      r_last_dc <= is_dcache(o_grant);
    end else begin
      r_last_dc <= r_last_dc;
    end
  end

  // Alternate classes when both request, otherwise serve whoever asks.
  always_comb begin
    o_grant = OWN_NONE;
    if ((w_dc_pick != OWN_NONE) && i_ic_req) begin
      o_grant = r_last_dc ? OWN_IC : w_dc_pick;
    end else if (w_dc_pick != OWN_NONE) begin
      o_grant = w_dc_pick;
    end else if (i_ic_req) begin
      o_grant = OWN_IC;
    end else begin
      o_grant = OWN_NONE;
    end
  end
`else
  // Fixed priority: dcache class first, icache last.
  always_comb begin
    o_grant = OWN_NONE;
    if (w_dc_pick != OWN_NONE) begin
      o_grant = w_dc_pick;
    end else if (i_ic_req) begin
      o_grant = OWN_IC;
    end else begin
      o_grant = OWN_NONE;
    end
  end
`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// Arbitrates icache refills, dcache refills and dcache writebacks onto one
// memory port, one transaction at a time (IDLE -> ISSUE -> WAIT).
// Optional macro: ARB_ROUND_ROBIN_EN (round-robin between icache and dcache).
module cache_mem_arbiter
  import pipeline_types::*;
#(
  parameter int LINE_WIDTH = BUS256_W,
  parameter int ADDR_WIDTH = BUS32_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icache_rd_req,
  input  logic [ADDR_WIDTH-1:0] icache_rd_addr,
  output logic                  icache_ret_valid,
  output logic [LINE_WIDTH-1:0] icache_ret_data,
  input  logic                  dcache_rd_req,
  input  logic [ADDR_WIDTH-1:0] dcache_rd_addr,
  output logic                  dcache_ret_valid,
  output logic [LINE_WIDTH-1:0] dcache_ret_data,
  input  logic                  dcache_wr_req,
  input  logic [ADDR_WIDTH-1:0] dcache_wr_addr,
  input  logic [LINE_WIDTH-1:0] dcache_wr_data,
  output logic                  dcache_wr_done,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic                  mem_ret_valid,
  input  logic [LINE_WIDTH-1:0] mem_rdata
);

  arb_state_e            r_state;
  arb_state_e            w_state_nxt;
  owner_e                r_owner;
  owner_e                r_done_owner;
  owner_e                w_grant;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_we;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic                  w_sel_we;
  logic [LINE_WIDTH-1:0] w_sel_wdata;
  logic                  w_take;
  logic                  w_complete;
  logic                  w_live;
  logic                  w_pulse;
  logic                  w_ic_req;
  logic                  w_dc_rd_req;
  logic                  w_dc_wr_req;

  // The requester just answered may still show its old level for one cycle;
  // hide it so that stale level cannot win a second grant.
  assign w_ic_req    = icache_rd_req & (r_done_owner != OWN_IC);
  assign w_dc_rd_req = dcache_rd_req & (r_done_owner != OWN_DC_RD);
  assign w_dc_wr_req = dcache_wr_req & (r_done_owner != OWN_DC_WR);

  cache_arb_grant u_grant (
`ifdef ARB_ROUND_ROBIN_EN
    .clk         (clk),
    .rst         (rst),
    .i_take      (w_take),
`endif
    .i_ic_req    (w_ic_req),
    .i_dc_rd_req (w_dc_rd_req),
    .i_dc_wr_req (w_dc_wr_req),
    .o_grant     (w_grant)
  );

  // Next-state logic; completion may come with the ack while still in ISSUE.
  always_comb begin
    w_state_nxt = r_state;
    w_take      = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_grant != OWN_NONE) begin
          w_take      = 1'b1;
          w_state_nxt = ST_ISSUE;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (mem_ack && mem_ret_valid) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (mem_ack) begin
          w_state_nxt = ST_WAIT;
        end else begin
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (mem_ret_valid) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_WAIT;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Steer the winning requester's fields toward the transaction latches.
  always_comb begin
    w_sel_addr  = {ADDR_WIDTH{1'b0}};
    w_sel_we    = 1'b0;
    w_sel_wdata = {LINE_WIDTH{1'b0}};
    case (w_grant)
      OWN_IC: begin
        w_sel_addr = icache_rd_addr;
      end
      OWN_DC_RD: begin
        w_sel_addr = dcache_rd_addr;
      end
      OWN_DC_WR: begin
        w_sel_addr  = dcache_wr_addr;
        w_sel_we    = 1'b1;
        w_sel_wdata = dcache_wr_data;
      end
      default: begin
        w_sel_addr  = {ADDR_WIDTH{1'b0}};
        w_sel_we    = 1'b0;
        w_sel_wdata = {LINE_WIDTH{1'b0}};
      end
    endcase
  end

  // State, owner and latched request fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_owner      <= OWN_NONE;
      r_done_owner <= OWN_NONE;
      r_addr       <= {ADDR_WIDTH{1'b0}};
      r_we         <= 1'b0;
      r_wdata      <= {LINE_WIDTH{1'b0}};
    end else begin
      r_state      <= w_state_nxt;
      r_done_owner <= w_pulse ? r_owner : OWN_NONE;
      if (w_take) begin
        r_owner <= w_grant;
        r_addr  <= w_sel_addr;
        r_we    <= w_sel_we;
        r_wdata <= w_sel_wdata;
      end else if (w_complete) begin
        r_owner <= OWN_NONE;
        r_addr  <= r_addr;
        r_we    <= r_we;
        r_wdata <= r_wdata;
      end else begin
        r_owner <= r_owner;
        r_addr  <= r_addr;
        r_we    <= r_we;
        r_wdata <= r_wdata;
      end
    end
  end

  // Every output is forced quiet while reset is high, even mid-transaction.
  assign w_live  = ~rst;
  assign w_pulse = w_live & w_complete;

  assign mem_req   = w_live & (r_state == ST_ISSUE);
  assign mem_we    = mem_req & r_we;
  assign mem_addr  = mem_req ? r_addr : {ADDR_WIDTH{1'b0}};
  assign mem_wdata = mem_req ? r_wdata : {LINE_WIDTH{1'b0}};

  assign icache_ret_valid = w_pulse & (r_owner == OWN_IC);
  assign dcache_ret_valid = w_pulse & (r_owner == OWN_DC_RD);
  assign dcache_wr_done   = w_pulse & (r_owner == OWN_DC_WR);
  assign icache_ret_data  = icache_ret_valid ? mem_rdata : {LINE_WIDTH{1'b0}};
  assign dcache_ret_data  = dcache_ret_valid ? mem_rdata : {LINE_WIDTH{1'b0}};

endmodule
